// File: rtl/alu_sequencer.sv
// Sequences one 8-bit 6502-style ALU operation at a time: drives the ALU for a cycle,
// post-processes its registered result, owns the N/V/Z/C flags and returns the result.
module alu_sequencer #(
    parameter logic [4:0] ALU_PASS_MODE = 5'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic       flag_wr,
    input  logic [3:0] flag_wdata,
    output logic       flag_n,
    output logic       flag_v,
    output logic       flag_z,
    output logic       flag_c,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [4:0] alu_mode,
    output logic       alu_carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_carry_out
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPTURE,
        RESP
    } state_e;

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_CMP = 4'd5,
        OP_ASL = 4'd6,
        OP_ROL = 4'd7
    } op_e;

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       a_msb_q, a_msb_d;
    logic       b_msb_q, b_msb_d;
    logic       c_snap_q, c_snap_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [4:0] alu_mode_q, alu_mode_d;
    logic       alu_cin_q, alu_cin_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;
    logic [3:0] flags_q, flags_d;

    logic [7:0] req_b_eff;
    logic [4:0] req_mode;
    logic       req_cin;
    logic [7:0] result;

    // Operand B as the ALU will actually see it: inverted for subtract/compare, zero for shifts.
    always_comb begin
        req_b_eff = req_b;
        req_mode  = 5'd0;
        req_cin   = 1'b0;
        case (req_op)
            OP_ADC: req_cin = flags_q[0];
            OP_SBC: begin
                req_b_eff = ~req_b;
                req_cin   = flags_q[0];
            end
            OP_CMP: begin
                req_b_eff = ~req_b;
                req_cin   = 1'b1;
            end
            OP_AND: req_mode = 5'd1;
            OP_ORA: req_mode = 5'd2;
            OP_EOR: req_mode = 5'd3;
            OP_ASL, OP_ROL: begin
                req_mode  = 5'd4;
                req_b_eff = 8'h00;
            end
            default: ;
        endcase
    end

    assign result = alu_out | {7'b0, (op_q == OP_ROL) & c_snap_q};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        c_snap_d   = c_snap_q;
        alu_a_d    = 8'h00;
        alu_b_d    = 8'h00;
        alu_mode_d = ALU_PASS_MODE;
        alu_cin_d  = 1'b0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        flags_d    = flag_wr ? flag_wdata : flags_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    a_msb_d  = req_a[7];
                    b_msb_d  = req_b_eff[7];
                    c_snap_d = flags_q[0];
                    if (req_op[3]) begin
                        rsp_data_d = req_a;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        alu_a_d    = req_a;
                        alu_b_d    = req_b_eff;
                        alu_mode_d = req_mode;
                        alu_cin_d  = req_cin;
                        state_d    = EXEC;
                    end
                end
            end
            EXEC: state_d = CAPTURE;
            CAPTURE: begin
                rsp_data_d = result;
                rsp_err_d  = 1'b0;
                // Op-derived flags override a simultaneous direct write; the rest keep the write.
                flags_d[3] = result[7];
                flags_d[1] = (result == 8'h00);
                if (op_q != OP_AND && op_q != OP_ORA && op_q != OP_EOR)
                    flags_d[0] = alu_carry_out;
                if (op_q == OP_ADC || op_q == OP_SBC)
                    flags_d[2] = (a_msb_q == b_msb_q) && (result[7] != a_msb_q);
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 4'd0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            c_snap_q   <= 1'b0;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            alu_mode_q <= ALU_PASS_MODE;
            alu_cin_q  <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
            flags_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            c_snap_q   <= c_snap_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_mode_q <= alu_mode_d;
            alu_cin_q  <= alu_cin_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            flags_q    <= flags_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign flag_n       = flags_q[3];
    assign flag_v       = flags_q[2];
    assign flag_z       = flags_q[1];
    assign flag_c       = flags_q[0];
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_mode     = alu_mode_q;
    assign alu_carry_in = alu_cin_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed requests push expected responses,
// a monitor pops and compares on every accepted response.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'd0;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       flag_wr = 1'b0;
    logic [3:0] flag_wdata = 4'b0000;
    logic       flag_n, flag_v, flag_z, flag_c;
    logic [7:0] alu_a, alu_b;
    logic [4:0] alu_mode;
    logic       alu_carry_in;
    logic [7:0] alu_out = 8'h00;
    logic       alu_carry_out = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [3:0] flags;
    } exp_t;

    exp_t sb[$];

    alu_sequencer #(.ALU_PASS_MODE(5'd5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flag_wr(flag_wr), .flag_wdata(flag_wdata),
        .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z), .flag_c(flag_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out)
    );

    always #5 clk = ~clk;

    // Behavioural ALU with a one-cycle registered output.
    always @(posedge clk) begin
        logic [8:0] sum;
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_carry_in};
        case (alu_mode)
            5'd0: {alu_carry_out, alu_out} <= sum;
            5'd1: {alu_carry_out, alu_out} <= {1'b0, alu_a & alu_b};
            5'd2: {alu_carry_out, alu_out} <= {1'b0, alu_a | alu_b};
            5'd3: {alu_carry_out, alu_out} <= {1'b0, alu_a ^ alu_b};
            5'd4: {alu_carry_out, alu_out} <= {alu_a, 1'b0};
            default: {alu_carry_out, alu_out} <= {1'b0, alu_a};
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", {24'b0, rsp_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
                checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                checkOutput("flags_nvzc", {28'b0, flag_n, flag_v, flag_z, flag_c}, {28'b0, e.flags});
            end
        end
    end

    task automatic setFlags(input logic [3:0] nvzc);
        @(negedge clk);
        flag_wr    = 1'b1;
        flag_wdata = nvzc;
        @(posedge clk);
        #1;
        flag_wr = 1'b0;
    endtask

    // Issues one request; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] expData, input logic expErr,
                                 input logic [3:0] expFlags, input bit push);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        if (push) begin
            e.data  = expData;
            e.err   = expErr;
            e.flags = expFlags;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitResponse(input string name, input int expLat);
        int lat;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput(name, lat, expLat);
        if (rsp_ready) begin
            @(posedge clk);
            #1;
            checkOutput({name, "_idle"}, {31'b0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #12;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", {24'b0, rsp_data}, 32'h00);
        checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("rst_flags", {28'b0, flag_n, flag_v, flag_z, flag_c}, 32'h0);
        checkOutput("rst_alu_ab", {16'b0, alu_a, alu_b}, 32'h0);
        checkOutput("rst_alu_mode", {27'b0, alu_mode}, 32'd5);
        checkOutput("rst_alu_cin", {31'b0, alu_carry_in}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADC 0x50+0x50, C=0 -> 0xA0, N1 V1 Z0 C0
        applyStimulus(4'd0, 8'h50, 8'h50, 8'hA0, 1'b0, 4'b1100, 1'b1);
        checkOutput("adc_alu_a", {24'b0, alu_a}, 32'h50);
        waitResponse("adc_latency", 3);

        // SBC 0x00-0x01, C=1 -> 0xFF, N1 V0 Z0 C0
        setFlags(4'b0001);
        applyStimulus(4'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 4'b1000, 1'b1);
        checkOutput("sbc_alu_b", {24'b0, alu_b}, 32'hFE);
        checkOutput("sbc_alu_mode", {27'b0, alu_mode}, 32'd0);
        checkOutput("sbc_alu_cin", {31'b0, alu_carry_in}, 32'd1);
        waitResponse("sbc_latency", 3);
        checkOutput("sbc_alu_mode_after", {27'b0, alu_mode}, 32'd5);

        // CMP 0x40,0x40 with V preset -> 0x00, N0 V1 Z1 C1
        setFlags(4'b0100);
        applyStimulus(4'd5, 8'h40, 8'h40, 8'h00, 1'b0, 4'b0111, 1'b1);
        checkOutput("cmp_alu_cin", {31'b0, alu_carry_in}, 32'd1);
        waitResponse("cmp_latency", 3);

        // ROL 0x80 with C=1 -> 0x01, N0 V0 Z0 C1
        setFlags(4'b0001);
        applyStimulus(4'd7, 8'h80, 8'h33, 8'h01, 1'b0, 4'b0001, 1'b1);
        checkOutput("rol_alu_b", {24'b0, alu_b}, 32'h00);
        checkOutput("rol_alu_mode", {27'b0, alu_mode}, 32'd4);
        waitResponse("rol_latency", 3);

        // Reserved opcode 9 -> echo a, err, flags unchanged, ALU untouched
        applyStimulus(4'd9, 8'h5A, 8'h11, 8'h5A, 1'b1, 4'b0001, 1'b1);
        checkOutput("rsv_alu_mode", {27'b0, alu_mode}, 32'd5);
        waitResponse("rsv_latency", 1);

        // AND with stalled consumer and a direct flag write during CAPTURE
        rsp_ready = 1'b0;
        applyStimulus(4'd2, 8'hF0, 8'h0F, 8'h00, 1'b0, 4'b0011, 1'b1);
        @(posedge clk);
        #1;
        flag_wr    = 1'b1;
        flag_wdata = 4'b1011;
        @(posedge clk);
        #1;
        flag_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("stall_rsp_data", {24'b0, rsp_data}, 32'h00);
            checkOutput("stall_req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        checkOutput("stall_req_ready_hs", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("stall_req_ready_after", {31'b0, req_ready}, 32'd1);

        // ADC aborted by reset during EXEC
        applyStimulus(4'd0, 8'h10, 8'h20, 8'h00, 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("abort_flags", {28'b0, flag_n, flag_v, flag_z, flag_c}, 32'h0);
        checkOutput("abort_alu_mode", {27'b0, alu_mode}, 32'd5);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_still_idle", {30'b0, req_ready, rsp_valid}, 32'b10);

        applyStimulus(4'd0, 8'h01, 8'h01, 8'h02, 1'b0, 4'b0000, 1'b1);
        waitResponse("post_abort_latency", 3);

        repeat (2) @(posedge clk);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
